// File: rtl/ula_mul_div.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with 32-bit W variants on a 64-bit datapath.
module ula_mul_div #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inicio,
  input  logic [2:0]      funct3,
  input  logic            palavra,
  input  logic [BITS-1:0] dina,
  input  logic [BITS-1:0] dinb,
  output logic [BITS-1:0] dout,
  output logic            pronto,
  output logic            ocupado
);
  localparam int CW = $clog2(BITS) + 1;
  localparam int W2 = 2 * BITS;

  typedef enum logic [1:0] {OCIOSO, CALC, CORRIGE} state_t;
  state_t state, state_nx;

  logic [2:0]      f3;
  logic            w, esp, neg_q, neg_r;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] opnd;
  logic [W2-1:0]   acc;

  logic            w_in, sa, sb, neg_a, neg_b, div0, ovf, accept;
  logic [BITS-1:0] ext_a, ext_b, mag_a, mag_b, min_neg, div_w, esp_res;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    w_in    = palavra && (BITS == 64);
    sa      = funct3[2] ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    sb      = funct3[2] ? !funct3[0] : (funct3 == 3'b001);
    ext_a   = dina;
    ext_b   = dinb;
    min_neg = {1'b1, {(BITS-1){1'b0}}};
    div_w   = dina;
    if (w_in) begin
      ext_a   = sa ? BITS'(signed'(dina[31:0])) : BITS'(dina[31:0]);
      ext_b   = sb ? BITS'(signed'(dinb[31:0])) : BITS'(dinb[31:0]);
      min_neg = BITS'(signed'(32'h8000_0000));
      div_w   = BITS'(signed'(dina[31:0]));
    end
    neg_a = sa && ext_a[BITS-1];
    neg_b = sb && ext_b[BITS-1];
    mag_a = neg_a ? -ext_a : ext_a;
    mag_b = neg_b ? -ext_b : ext_b;
    div0  = funct3[2] && (ext_b == '0);
    ovf   = funct3[2] && sa && (ext_a == min_neg) && (ext_b == '1);
    // Special-case results are final values, already widened for W ops.
    if (funct3[1] && ovf)      esp_res = '0;
    else if (funct3[1] || ovf) esp_res = div_w;
    else                       esp_res = '1;
    accept = (state == OCIOSO) && inicio;
  end

  logic [BITS:0]   mul_sum, trial;
  logic [BITS+1:0] div_diff;
  logic [BITS-1:0] addend;
  logic            borrow;

  always_comb begin
    addend   = acc[0] ? opnd : '0;
    mul_sum  = {1'b0, acc[W2-1:BITS]} + {1'b0, addend};
    trial    = {acc[W2-1:BITS], acc[BITS-1]};
    div_diff = {1'b0, trial} - {2'b00, opnd};
    borrow   = div_diff[BITS+1];
  end

  logic [W2-1:0]   p_al, p_s;
  logic [BITS-1:0] q_s, r_s, sel, res;

  always_comb begin
    // W multiplies finish with the product sitting 32 bits above the LSB.
    p_al = w ? (acc >> 32) : acc;
    p_s  = neg_q ? -p_al : p_al;
    q_s  = neg_q ? -acc[BITS-1:0] : acc[BITS-1:0];
    r_s  = neg_r ? -acc[W2-1:BITS] : acc[W2-1:BITS];
    if (f3[2])                 sel = f3[1] ? r_s : q_s;
    else if (f3[1:0] == 2'b00) sel = p_s[BITS-1:0];
    else if (w)                sel = BITS'(p_s[63:32]);
    else                       sel = p_s[W2-1:BITS];
    res = w ? BITS'(signed'(sel[31:0])) : sel;
    if (esp) res = acc[BITS-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      OCIOSO:  if (inicio) state_nx = (div0 || ovf) ? CORRIGE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = CORRIGE;
      CORRIGE: state_nx = OCIOSO;
      default: state_nx = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= OCIOSO;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f3     <= '0;
      w      <= 1'b0;
      esp    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      dout   <= '0;
      pronto <= 1'b0;
    end else begin
      pronto <= (state == CORRIGE);
      if (state == CORRIGE) dout <= res;
      if (accept) begin
        f3    <= funct3;
        w     <= w_in;
        esp   <= div0 || ovf;
        cnt   <= w_in ? CW'(32) : CW'(BITS);
        neg_q <= neg_a ^ neg_b;
        neg_r <= funct3[2] && neg_a;
        if (div0 || ovf) begin
          acc <= {{BITS{1'b0}}, esp_res};
        end else if (funct3[2]) begin
          opnd <= mag_b;
          acc  <= {{BITS{1'b0}}, (w_in ? (mag_a << 32) : mag_a)};
        end else begin
          opnd <= mag_a;
          acc  <= {{BITS{1'b0}}, mag_b};
        end
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (f3[2]) acc <= {(borrow ? trial[BITS-1:0] : div_diff[BITS-1:0]), acc[BITS-2:0], !borrow};
        else       acc <= {mul_sum, acc[BITS-1:1]};
      end
    end
  end

  assign ocupado = (state != OCIOSO);

endmodule

// File: tb/tb_ula_mul_div.sv
// Directed-vector bench for ula_mul_div: a table of operations with hand-computed
// results and latencies, plus sequences for dropped starts, back-to-back and abort.
module tb_ula_mul_div;
  localparam int BITS = 64;

  logic            clk = 1'b0;
  logic            reset_n, inicio, palavra, pronto, ocupado;
  logic [2:0]      funct3;
  logic [BITS-1:0] dina, dinb, dout;

  int n_vec = 0;
  int n_err = 0;

  ula_mul_div #(.BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .funct3(funct3),
    .palavra(palavra), .dina(dina), .dinb(dinb),
    .dout(dout), .pronto(pronto), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [2:0] f3, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] expv, input int lat);
    vec_t v;
    v.name = nm; v.f3 = f3; v.w = w; v.a = a; v.b = b; v.expv = expv; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, expv);
    end
  endtask

  // Caller is just past a rising edge; the next edge is the accepting edge 0.
  task automatic launch(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
    funct3 = f3; palavra = w; dina = a; dinb = b; inicio = 1'b1;
    @(posedge clk); #1;
    inicio  = 1'b0;
    dina    = {$urandom, $urandom};
    dinb    = {$urandom, $urandom};
    funct3  = 3'($urandom);
    palavra = 1'($urandom);
    check({name, " ocupado@0"}, 64'(ocupado), 64'd1);
    check({name, " pronto@0"}, 64'(pronto), 64'd0);
  endtask

  task automatic wait_done(output int n, output int gaps);
    n = 0;
    gaps = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (pronto) break;
      if (!ocupado) gaps++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, gaps;
    launch(v.name, v.f3, v.w, v.a, v.b);
    wait_done(n, gaps);
    check({v.name, " latency"}, 64'(n), 64'(v.lat));
    check({v.name, " dout"}, dout, v.expv);
    check({v.name, " ocupado@L"}, 64'(ocupado), 64'd0);
    check({v.name, " busy gaps"}, 64'(gaps), 64'd0);
  endtask

  initial begin
    int n, gaps, seen;
    vec_t v;
    reset_n = 1'b0; inicio = 1'b0; funct3 = '0; palavra = 1'b0; dina = '0; dinb = '0;

    add("MUL 7*-3",      3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    add("MULHU ff*ff",   3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add("MULHSU ff*ff",  3'b010, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add("MULH -1*-1",    3'b001, 1'b0, '1, '1, 64'h0, 65);
    add("MULH min*min",  3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h4000_0000_0000_0000, 65);
    add("DIV 5/0",       3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add("REMU 5/0",      3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    add("DIV ovf",       3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    add("REM ovf",       3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    add("DIVW -7/2",     3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    add("REMW -7/2",     3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    add("DIV -100/7",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    add("REM -100/7",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    add("DIV 7/-2",      3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add("REM 7/-2",      3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    add("DIVU ff/16",    3'b101, 1'b0, '1, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    add("MULW 3*2^30",   3'b000, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'h0000_0000_4000_0000,
        64'hFFFF_FFFF_C000_0000, 33);
    add("REMUW x/0",     3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
        64'hFFFF_FFFF_8000_0001, 1);
    add("DIVW ovf",      3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1);

    #2;
    check("reset dout", dout, 64'h0);
    check("reset pronto", 64'(pronto), 64'd0);
    check("reset ocupado", 64'(ocupado), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Start pulse at edge 10 of a running MUL must be dropped.
    launch("MUL ignore", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 9) begin
        inicio = 1'b1; funct3 = 3'b100; palavra = 1'b0; dina = 64'd5; dinb = 64'd0;
      end
      if (n == 10) inicio = 1'b0;
      if (pronto) break;
    end
    check("MUL ignore latency", 64'(n), 64'd65);
    check("MUL ignore dout", dout, 64'hFFFF_FFFF_FFFF_FFEB);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pronto || ocupado) seen++;
    end
    check("dropped start stays idle", 64'(seen), 64'd0);
    check("dout holds", dout, 64'hFFFF_FFFF_FFFF_FFEB);

    // Issue in the pronto cycle of the previous op.
    launch("b2b first", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done(n, gaps);
    check("b2b first dout", dout, 64'h4000_0000_0000_0000);
    launch("b2b second", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    check("b2b hold dout", dout, 64'h4000_0000_0000_0000);
    wait_done(n, gaps);
    check("b2b second latency", 64'(n), 64'd65);
    check("b2b second dout", dout, 64'hFFFF_FFFF_FFFF_FFEB);

    // Abort a DIVU mid-calculation.
    launch("DIVU abort", 3'b101, 1'b0, 64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort dout", dout, 64'h0);
    check("abort pronto", 64'(pronto), 64'd0);
    check("abort ocupado", 64'(ocupado), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (pronto || ocupado) seen++;
    end
    check("no pronto after abort", 64'(seen), 64'd0);

    v.name = "DIVU 100/7"; v.f3 = 3'b101; v.w = 1'b0; v.a = 64'd100; v.b = 64'd7;
    v.expv = 64'd14; v.lat = 65;
    run_vec(v);
    v.name = "REMU 100/7"; v.f3 = 3'b111; v.expv = 64'd2;
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
